// File: rtl/dbus_timer_pkg.sv
// Shared constants for the data-bus timer slave: register map, bit positions,
// FSM encoding and reset values.
package dbus_timer_pkg;

    localparam logic [2:0] ADDR_CTRL    = 3'd0;
    localparam logic [2:0] ADDR_PRESC   = 3'd1;
    localparam logic [2:0] ADDR_CMP     = 3'd2;
    localparam logic [2:0] ADDR_CNT     = 3'd3;
    localparam logic [2:0] ADDR_STATUS  = 3'd4;
    localparam logic [2:0] ADDR_SCRATCH = 3'd5;
    localparam logic [2:0] ADDR_ID      = 3'd6;
    localparam logic [2:0] ADDR_CAPT    = 3'd7;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_RELOAD  = 1;
    localparam int CTRL_IRQ_EN  = 2;

    localparam int ST_MATCH     = 0;
    localparam int ST_RUNNING   = 1;
    localparam int ST_CAPF      = 2;

    localparam logic [7:0] RST_PRESC = 8'h00;
    localparam logic [7:0] RST_CMP   = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } timer_state_e;

endpackage

// File: rtl/dbus_timer_prescaler.sv
// Prescaler for the timer: one-cycle tick every presc_i+1 clocks while enabled,
// built as a down-counter that reloads on terminal count or restart.
module dbus_timer_prescaler #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic             restart_i,
    input  logic [WIDTH-1:0] presc_i,
    output logic             tick_o
);

    logic [WIDTH-1:0] count_q, count_d;

    assign tick_o = en_i && !restart_i && (count_q == '0);

    // presc_i is the value PRESC will hold after this edge, so a write reloads fresh
    always_comb begin
        count_d = count_q - 1'b1;
        if (restart_i || !en_i || (count_q == '0)) begin
            count_d = presc_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/dbus_timer_slave.sv
// Data-bus timer slave: register file, read mux and counter FSM.
// Optional capture input enabled by defining TIMER_CAPTURE_EN.
//   state | meaning
//   IDLE  | counter frozen, waiting for CTRL.EN
//   RUN   | counting on prescaler ticks, compare active
//   DONE  | one-shot finished, counter frozen until re-enabled
module dbus_timer_slave
    import dbus_timer_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 3,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 'hA5
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    output logic [DATA_WIDTH-1:0] dout_o,
    input  logic                  wr_i,
`ifdef TIMER_CAPTURE_EN
    input  logic                  capture_i,
`endif
    output logic                  irq_o,
    output logic                  match_o
);

    timer_state_e          state_q;
    logic [2:0]            ctrl_q;
    logic [DATA_WIDTH-1:0] presc_q, cmp_q, cnt_q, scratch_q;
    logic [DATA_WIDTH-1:0] presc_d, capt, rd_data;
    logic                  match_flag_q, match_q, capf;
    logic                  tick, ev_tick, hit;

    logic [2:0] sel;
    logic       in_map;
    assign sel    = addr_i[2:0];
    assign in_map = ((addr_i >> 3) == '0);

    logic wr_ctrl, wr_presc, wr_cmp, wr_cnt, wr_status, wr_scratch;
    assign wr_ctrl    = wr_i && in_map && (sel == ADDR_CTRL);
    assign wr_presc   = wr_i && in_map && (sel == ADDR_PRESC);
    assign wr_cmp     = wr_i && in_map && (sel == ADDR_CMP);
    assign wr_cnt     = wr_i && in_map && (sel == ADDR_CNT);
    assign wr_status  = wr_i && in_map && (sel == ADDR_STATUS);
    assign wr_scratch = wr_i && in_map && (sel == ADDR_SCRATCH);

    assign presc_d = wr_presc ? din_i : presc_q;

    dbus_timer_prescaler #(.WIDTH(DATA_WIDTH)) u_presc (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .en_i      (state_q == RUN),
        .restart_i (wr_ctrl || wr_presc),
        .presc_i   (presc_d),
        .tick_o    (tick)
    );

    // A bus write to CNT or CTRL owns the counter for that cycle; the tick is dropped.
    assign ev_tick = tick && !wr_cnt && !wr_ctrl;
    assign hit     = ev_tick && (cnt_q == cmp_q);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            ctrl_q       <= '0;
            presc_q      <= DATA_WIDTH'(RST_PRESC);
            cmp_q        <= DATA_WIDTH'(RST_CMP);
            cnt_q        <= '0;
            scratch_q    <= '0;
            match_flag_q <= 1'b0;
            match_q      <= 1'b0;
        end else begin
            match_q <= hit;
            if (wr_presc)   presc_q   <= din_i;
            if (wr_cmp)     cmp_q     <= din_i;
            if (wr_scratch) scratch_q <= din_i;
            if (wr_ctrl)    ctrl_q    <= din_i[2:0];
            if (hit) begin
                match_flag_q <= 1'b1;
            end else if (wr_status && din_i[ST_MATCH]) begin
                match_flag_q <= 1'b0;
            end
            case (state_q)
                IDLE: if (wr_ctrl && din_i[CTRL_EN]) state_q <= RUN;
                RUN: begin
                    if (wr_ctrl && !din_i[CTRL_EN]) begin
                        state_q <= IDLE;
                    end else if (hit) begin
                        if (ctrl_q[CTRL_RELOAD]) begin
                            cnt_q <= '0;
                        end else begin
                            ctrl_q[CTRL_EN] <= 1'b0;
                            state_q         <= DONE;
                        end
                    end else if (ev_tick) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: if (wr_ctrl && din_i[CTRL_EN]) begin
                    cnt_q   <= '0;
                    state_q <= RUN;
                end
                default: state_q <= IDLE;
            endcase
            if (wr_cnt) cnt_q <= din_i;
        end
    end

`ifdef TIMER_CAPTURE_EN
    logic [1:0]            cap_sync_q;
    logic                  cap_prev_q, capf_q, cap_edge;
    logic [DATA_WIDTH-1:0] capt_q;

    assign cap_edge = cap_sync_q[1] && !cap_prev_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cap_sync_q <= '0;
            cap_prev_q <= 1'b0;
            capt_q     <= '0;
            capf_q     <= 1'b0;
        end else begin
            cap_sync_q <= {cap_sync_q[0], capture_i};
            cap_prev_q <= cap_sync_q[1];
            if (cap_edge) capt_q <= cnt_q;
            if (cap_edge) begin
                capf_q <= 1'b1;
            end else if (wr_status && din_i[ST_CAPF]) begin
                capf_q <= 1'b0;
            end
        end
    end

    assign capt = capt_q;
    assign capf = capf_q;
`else
    assign capt = '0;
    assign capf = 1'b0;
`endif

    always_comb begin
        rd_data = '0;
        if (in_map) begin
            case (sel)
                ADDR_CTRL:    rd_data[2:0] = ctrl_q;
                ADDR_PRESC:   rd_data = presc_q;
                ADDR_CMP:     rd_data = cmp_q;
                ADDR_CNT:     rd_data = cnt_q;
                ADDR_STATUS: begin
                    rd_data[ST_MATCH]   = match_flag_q;
                    rd_data[ST_RUNNING] = (state_q == RUN);
                    rd_data[ST_CAPF]    = capf;
                end
                ADDR_SCRATCH: rd_data = scratch_q;
                ADDR_ID:      rd_data = ID_VALUE;
                ADDR_CAPT:    rd_data = capt;
                default:      rd_data = '0;
            endcase
        end
    end

    assign dout_o  = rd_data;
    assign irq_o   = match_flag_q && ctrl_q[CTRL_IRQ_EN];
    assign match_o = match_q;

endmodule
